// File: rtl/openila_capture_ctrl_pkg.sv
// Shared types and helpers for the ILA capture sequencer.
// Holds the sequencer state encoding and small elaboration-time arithmetic helpers.
package openila_capture_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StPretrig,
        StWaitTrig,
        StPosttrig,
        StDone,
        StRdAddr,
        StRdData,
        StSend
    } cap_state_e;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/openila_capture_ctrl_serialiser.sv
// Splits one stored sample into bytes, least-significant byte first, with valid/ready output.
// The loaded word is zero-padded to a whole number of bytes.
module openila_capture_ctrl_serialiser
    import openila_capture_ctrl_pkg::*;
#(
    parameter int unsigned W_SAMPLE = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clear,
    input  logic                i_load,
    input  logic [W_SAMPLE-1:0] i_data,
    input  logic                i_ready,
    output logic [BYTE_W-1:0]   o_byte,
    output logic                o_valid,
    output logic                o_last
);

    localparam int unsigned NB      = ceil_div(W_SAMPLE, BYTE_W);
    localparam int unsigned W_SHIFT = BYTE_W * NB;
    localparam int unsigned W_IDX   = idx_width(NB);

    logic [W_SHIFT-1:0] r_shift;
    logic               r_valid;
    logic [W_IDX-1:0]   r_idx;

    logic w_accept;
    logic w_last_byte;

    assign w_accept    = r_valid & i_ready;
    assign w_last_byte = (r_idx == W_IDX'(NB - 1));
    assign o_last      = w_accept & w_last_byte;
    assign o_byte      = r_shift[BYTE_W-1:0];
    assign o_valid     = r_valid;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_shift <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
        end else if (i_load) begin
            r_shift <= W_SHIFT'(i_data);
            r_valid <= 1'b1;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_shift <= r_shift >> BYTE_W;
            if (w_last_byte) begin
                r_valid <= 1'b0;
                r_idx   <= '0;
            end else begin
                r_idx <= r_idx + W_IDX'(1);
            end
        end
    end

endmodule

// File: rtl/openila_capture_ctrl.sv
// Ring-buffer capture sequencer with run-time pre-trigger window and byte-serial readout.
// The stored window is always DEPTH samples, streamed oldest first.
module openila_capture_ctrl
    import openila_capture_ctrl_pkg::*;
#(
    parameter int unsigned W_SAMPLE = 8,
    parameter int unsigned W_ADDR   = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [W_SAMPLE-1:0] i_sample,
    input  logic                i_sample_valid,
    input  logic                i_trigger,
    input  logic                i_arm,
    input  logic                i_abort,
    input  logic [W_ADDR-1:0]   i_pretrig_depth,
    input  logic                i_rd_start,
    output logic [W_ADDR-1:0]   o_mem_addr,
    output logic                o_mem_wen,
    output logic [W_SAMPLE-1:0] o_mem_wdata,
    input  logic [W_SAMPLE-1:0] i_mem_rdata,
    output logic [BYTE_W-1:0]   o_comm_out,
    output logic                o_comm_out_valid,
    input  logic                i_comm_out_ready,
    output logic                o_busy,
    output logic                o_triggered,
    output logic                o_done
);

    localparam int unsigned DEPTH = 2 ** W_ADDR;
    localparam int unsigned W_CNT = W_ADDR + 1;

    cap_state_e          r_state, w_state_next;
    logic [W_ADDR-1:0]   r_p, w_p_next;
    logic [W_CNT-1:0]    r_fill_cnt, w_fill_cnt_next;
    logic [W_CNT-1:0]    r_post_cnt, w_post_cnt_next;
    logic [W_ADDR-1:0]   r_wptr, w_wptr_next;
    logic [W_ADDR-1:0]   r_trig_addr, w_trig_addr_next;
    logic [W_ADDR-1:0]   r_rptr, w_rptr_next;
    logic [W_CNT-1:0]    r_rd_cnt, w_rd_cnt_next;
    logic                r_triggered, w_triggered_next;
    logic                r_done, w_done_next;
    logic [W_ADDR-1:0]   r_mem_addr, w_mem_addr_next;
    logic                r_mem_wen, w_mem_wen_next;
    logic [W_SAMPLE-1:0] r_mem_wdata, w_mem_wdata_next;

    logic              w_capturing;
    logic              w_ser_load;
    logic              w_ser_clear;
    logic              w_ser_last;
    logic [W_CNT-1:0]  w_fill_inc;
    logic [W_CNT-1:0]  w_post_init;
    logic [W_ADDR-1:0] w_rd_base;
    logic [W_ADDR-1:0] w_rptr_inc;

    assign w_capturing = (r_state == StPretrig) || (r_state == StWaitTrig) ||
                         (r_state == StPosttrig);
    assign w_fill_inc  = r_fill_cnt + W_CNT'(1);
    // Samples still to store after the trigger so the window totals DEPTH.
    assign w_post_init = W_CNT'(DEPTH) - {1'b0, r_p} - W_CNT'(1);
    assign w_rd_base   = r_trig_addr - r_p;
    assign w_rptr_inc  = r_rptr + W_ADDR'(1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_p         <= '0;
            r_fill_cnt  <= '0;
            r_post_cnt  <= '0;
            r_wptr      <= '0;
            r_trig_addr <= '0;
            r_rptr      <= '0;
            r_rd_cnt    <= '0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wen   <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_next;
            r_p         <= w_p_next;
            r_fill_cnt  <= w_fill_cnt_next;
            r_post_cnt  <= w_post_cnt_next;
            r_wptr      <= w_wptr_next;
            r_trig_addr <= w_trig_addr_next;
            r_rptr      <= w_rptr_next;
            r_rd_cnt    <= w_rd_cnt_next;
            r_triggered <= w_triggered_next;
            r_done      <= w_done_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wen   <= w_mem_wen_next;
            r_mem_wdata <= w_mem_wdata_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_p_next         = r_p;
        w_fill_cnt_next  = r_fill_cnt;
        w_post_cnt_next  = r_post_cnt;
        w_wptr_next      = r_wptr;
        w_trig_addr_next = r_trig_addr;
        w_rptr_next      = r_rptr;
        w_rd_cnt_next    = r_rd_cnt;
        w_triggered_next = r_triggered;
        w_done_next      = r_done;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wen_next   = 1'b0;
        w_mem_wdata_next = r_mem_wdata;
        w_ser_load       = 1'b0;
        w_ser_clear      = 1'b0;

        if (w_capturing && i_sample_valid) begin
            w_mem_wen_next   = 1'b1;
            w_mem_addr_next  = r_wptr;
            w_mem_wdata_next = i_sample;
            w_wptr_next      = r_wptr + W_ADDR'(1);
        end

        unique case (r_state)
            StIdle: begin
                if (i_arm) begin
                    w_p_next         = i_pretrig_depth;
                    w_fill_cnt_next  = '0;
                    w_triggered_next = 1'b0;
                    w_done_next      = 1'b0;
                    w_state_next     = (i_pretrig_depth == '0) ? StWaitTrig : StPretrig;
                end
            end
            StPretrig: begin
                if (i_sample_valid) begin
                    w_fill_cnt_next = w_fill_inc;
                    if (w_fill_inc == {1'b0, r_p}) begin
                        w_state_next = StWaitTrig;
                    end
                end
            end
            StWaitTrig: begin
                if (i_sample_valid && i_trigger) begin
                    w_trig_addr_next = r_wptr;
                    w_triggered_next = 1'b1;
                    w_post_cnt_next  = w_post_init;
                    if (w_post_init == '0) begin
                        w_done_next  = 1'b1;
                        w_state_next = StDone;
                    end else begin
                        w_state_next = StPosttrig;
                    end
                end
            end
            StPosttrig: begin
                if (i_sample_valid) begin
                    w_post_cnt_next = r_post_cnt - W_CNT'(1);
                    if (r_post_cnt == W_CNT'(1)) begin
                        w_done_next  = 1'b1;
                        w_state_next = StDone;
                    end
                end
            end
            StDone: begin
                if (i_rd_start) begin
                    w_rptr_next     = w_rd_base;
                    w_rd_cnt_next   = W_CNT'(DEPTH);
                    w_mem_addr_next = w_rd_base;
                    w_state_next    = StRdAddr;
                end
            end
            StRdAddr: begin
                w_state_next = StRdData;
            end
            StRdData: begin
                w_ser_load   = 1'b1;
                w_state_next = StSend;
            end
            StSend: begin
                if (w_ser_last) begin
                    w_rptr_next   = w_rptr_inc;
                    w_rd_cnt_next = r_rd_cnt - W_CNT'(1);
                    if (r_rd_cnt == W_CNT'(1)) begin
                        w_done_next  = 1'b0;
                        w_state_next = StIdle;
                    end else begin
                        w_mem_addr_next = w_rptr_inc;
                        w_state_next    = StRdAddr;
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        // Abort wins over everything; the dropped sample does not advance wptr.
        if (i_abort) begin
            w_state_next     = StIdle;
            w_mem_wen_next   = 1'b0;
            w_wptr_next      = r_wptr;
            w_triggered_next = 1'b0;
            w_done_next      = 1'b0;
            w_ser_clear      = 1'b1;
        end
    end

    openila_capture_ctrl_serialiser #(
        .W_SAMPLE (W_SAMPLE)
    ) u_serialiser (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (w_ser_clear),
        .i_load  (w_ser_load),
        .i_data  (i_mem_rdata),
        .i_ready (i_comm_out_ready),
        .o_byte  (o_comm_out),
        .o_valid (o_comm_out_valid),
        .o_last  (w_ser_last)
    );

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wen   = r_mem_wen;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = (r_state != StIdle);
    assign o_triggered = r_triggered;
    assign o_done      = r_done;

endmodule

// File: tb/tb_openila_capture_ctrl.sv
// Bench for openila_capture_ctrl: 12-bit samples, 16-deep ring, behavioural memory.
// Expected readout bytes are queued while samples are driven and popped on each accepted byte.
module tb_openila_capture_ctrl;

    localparam int unsigned W_SAMPLE = 12;
    localparam int unsigned W_ADDR   = 4;
    localparam int          DEPTH    = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [W_SAMPLE-1:0] sample = '0;
    logic                sample_valid = 1'b0;
    logic                trigger = 1'b0;
    logic                arm = 1'b0;
    logic                abort = 1'b0;
    logic [W_ADDR-1:0]   pretrig_depth = '0;
    logic                rd_start = 1'b0;
    logic [W_ADDR-1:0]   mem_addr;
    logic                mem_wen;
    logic [W_SAMPLE-1:0] mem_wdata;
    logic [W_SAMPLE-1:0] mem_rdata = '0;
    logic [7:0]          comm_out;
    logic                comm_out_valid;
    logic                comm_out_ready = 1'b0;
    logic                busy;
    logic                triggered;
    logic                done;

    logic [W_SAMPLE-1:0] mem [DEPTH];
    logic [7:0]          exp_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    openila_capture_ctrl #(
        .W_SAMPLE (W_SAMPLE),
        .W_ADDR   (W_ADDR)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_sample         (sample),
        .i_sample_valid   (sample_valid),
        .i_trigger        (trigger),
        .i_arm            (arm),
        .i_abort          (abort),
        .i_pretrig_depth  (pretrig_depth),
        .i_rd_start       (rd_start),
        .o_mem_addr       (mem_addr),
        .o_mem_wen        (mem_wen),
        .o_mem_wdata      (mem_wdata),
        .i_mem_rdata      (mem_rdata),
        .o_comm_out       (comm_out),
        .o_comm_out_valid (comm_out_valid),
        .i_comm_out_ready (comm_out_ready),
        .o_busy           (busy),
        .o_triggered      (triggered),
        .o_done           (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Arms with pretrig p, streams base+n for each valid sample n, trigger honoured at n==trig_n.
    // Triggers are also raised on pre-trigger samples and on every invalid cycle; all are ignored.
    task automatic run_capture(input int p, input int trig_n, input bit gaps,
                               input logic [W_SAMPLE-1:0] base);
        int n;
        int cyc;
        int total;
        logic vld;
        logic [W_SAMPLE-1:0] v;
        exp_q.delete();
        @(negedge clk);
        arm = 1'b1;
        pretrig_depth = W_ADDR'(p);
        @(negedge clk);
        arm = 1'b0;
        check_eq("arm_busy", 32'(busy), 32'd1);
        check_eq("arm_trig_clr", 32'(triggered), 32'd0);
        n = 0;
        cyc = 0;
        total = trig_n + DEPTH - p;
        while (n < total && cyc < 1000) begin
            vld = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            sample_valid = vld;
            if (vld) begin
                v = base + W_SAMPLE'(n);
                sample = v;
                trigger = (n == trig_n) || (n < p && (n % 2) == 0);
                if (n >= trig_n - p) begin
                    exp_q.push_back(v[7:0]);
                    exp_q.push_back({4'h0, v[11:8]});
                end
                n++;
            end else begin
                sample = 12'hFFF;
                trigger = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        sample_valid = 1'b0;
        trigger = 1'b0;
        check_eq("cap_done", 32'(done), 32'd1);
        check_eq("cap_triggered", 32'(triggered), 32'd1);
        check_eq("cap_busy", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic readout(input int ready_pct);
        int cyc;
        bit prev_stall;
        logic [7:0] prev_byte;
        logic [7:0] e;
        @(negedge clk);
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        prev_stall = 1'b0;
        prev_byte = '0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            if (prev_stall) check_eq("stall_stable", {23'd0, comm_out_valid, comm_out},
                                     {23'd0, 1'b1, prev_byte});
            comm_out_ready = ($urandom_range(0, 99) < ready_pct);
            if (comm_out_valid && comm_out_ready) begin
                e = exp_q.pop_front();
                check_eq("byte", 32'(comm_out), 32'(e));
            end
            prev_stall = comm_out_valid && !comm_out_ready;
            prev_byte = comm_out;
            @(negedge clk);
            cyc++;
        end
        comm_out_ready = 1'b0;
        check_eq("readout_left", 32'(exp_q.size()), 32'd0);
        check_eq("rd_end_busy", 32'(busy), 32'd0);
        check_eq("rd_end_done", 32'(done), 32'd0);
        check_eq("rd_end_valid", 32'(comm_out_valid), 32'd0);
    endtask

    task automatic abort_in_posttrig();
        @(negedge clk);
        arm = 1'b1;
        pretrig_depth = 4'd2;
        @(negedge clk);
        arm = 1'b0;
        for (int n = 0; n < 8; n++) begin
            sample_valid = 1'b1;
            sample = 12'(n);
            trigger = (n == 4);
            @(negedge clk);
        end
        trigger = 1'b0;
        check_eq("post_triggered", 32'(triggered), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        sample_valid = 1'b0;
        check_eq("abort_post_busy", 32'(busy), 32'd0);
        check_eq("abort_post_trig", 32'(triggered), 32'd0);
        check_eq("abort_post_wen", 32'(mem_wen), 32'd0);
        @(negedge clk);
        check_eq("abort_post_idle_wen", 32'(mem_wen), 32'd0);
    endtask

    task automatic abort_in_send();
        int cyc;
        @(negedge clk);
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        comm_out_ready = 1'b1;
        repeat (6) @(negedge clk);
        comm_out_ready = 1'b0;
        cyc = 0;
        while (!comm_out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("send_valid", 32'(comm_out_valid), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_send_valid", 32'(comm_out_valid), 32'd0);
        check_eq("abort_send_busy", 32'(busy), 32'd0);
        check_eq("abort_send_done", 32'(done), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_wen", 32'(mem_wen), 32'd0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check_eq("rst_comm_out", 32'(comm_out), 32'd0);
        check_eq("rst_valid", 32'(comm_out_valid), 32'd0);
        check_eq("rst_status", {29'd0, busy, triggered, done}, 32'd0);
        rst_n = 1'b1;

        run_capture(4, 20, 1'b0, 12'h000);
        readout(100);

        run_capture(0, 0, 1'b0, 12'h000);
        readout(100);

        run_capture(15, 40, 1'b0, 12'h500);
        @(negedge clk);
        arm = 1'b1;
        pretrig_depth = 4'd3;
        @(negedge clk);
        arm = 1'b0;
        check_eq("arm_in_done", {30'd0, busy, done}, 32'd3);
        readout(30);

        run_capture(6, 25, 1'b1, 12'h7A0);
        readout(30);

        abort_in_posttrig();
        run_capture(3, 10, 1'b0, 12'h123);
        readout(50);

        run_capture(5, 9, 1'b0, 12'hABC);
        abort_in_send();
        run_capture(2, 2, 1'b1, 12'h200);
        readout(70);

        run_capture(1, 3, 1'b0, 12'h0F0);
        @(negedge clk);
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        comm_out_ready = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        comm_out_ready = 1'b0;
        check_eq("midrd_rst", {23'd0, comm_out_valid, busy, done, triggered, mem_wen, comm_out[3:0]},
                 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
